// File: rtl/prod_accum_if.sv
// prod_accum_if: product-in / frame-sum-out valid/ready bus
interface prod_accum_if #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 19
);
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             in_ready;
    logic             out_valid;
    logic [ACC_W-1:0] out_sum;
    logic [7:0]       out_frame;
    logic             out_ready;
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_frame
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_frame
    );
endinterface

// File: rtl/prod_accum.sv
// prod_accum: sums every N accepted products into a sequenced frame sum
module prod_accum #(
    parameter int IN_W = 16,
    parameter int N    = 8,
    localparam int CNT_W = $clog2(N),
    localparam int ACC_W = IN_W + $clog2(N)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    prod_accum_if.slave bus
);
    typedef enum logic {ACC, OUT} state_t;
    state_t           state_q;
    logic [ACC_W-1:0] acc_q, sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       frame_q, fcnt_q;
    logic             valid_q, accept;
    assign bus.in_ready  = (state_q == ACC) || bus.out_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_frame = frame_q;
    // a flush discards the beat even though in_ready may be high
    assign accept = bus.in_valid && bus.in_ready && !clr_i;
    assign sum_d  = acc_q + ACC_W'(bus.in_data);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            frame_q <= '0;
            fcnt_q  <= '0;
            valid_q <= 1'b0;
        end else if (clr_i) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (state_q == OUT && bus.out_ready) begin
                state_q <= ACC;
                valid_q <= 1'b0;
            end
            // acc is already zero in OUT, so a same-cycle beat starts the next frame
            if (accept) begin
                if (cnt_q == CNT_W'(N - 1)) begin
                    sum_q   <= sum_d;
                    frame_q <= fcnt_q;
                    fcnt_q  <= fcnt_q + 8'd1;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    valid_q <= 1'b1;
                    state_q <= OUT;
                end else begin
                    acc_q <= sum_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum: directed checks of frame summing, back-pressure, wrap, reset and flush
module tb_prod_accum;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr_i = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   exp_f;
    int   prev_f;
    logic wrap_seen;
    prod_accum_if #(.IN_W(16), .ACC_W(19)) bus ();
    prod_accum #(.IN_W(16), .N(8)) dut (.clk(clk), .rst_n(rst_n), .clr_i(clr_i), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic beat(input logic [15:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
    endtask
    task automatic idle();
        bus.in_valid = 1'b0;
        step();
    endtask
    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_sum", 32'(bus.out_sum), 0);
        check("rst_frame", 32'(bus.out_frame), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        // 1: basic frame and single-cycle pulse
        for (int i = 0; i < 7; i++) beat(16'd100);
        check("t1_not_early", 32'(bus.out_valid), 0);
        beat(16'd100);
        check("t1_valid", 32'(bus.out_valid), 1);
        check("t1_sum", 32'(bus.out_sum), 800);
        check("t1_frame", 32'(bus.out_frame), 0);
        idle();
        check("t1_pulse", 32'(bus.out_valid), 0);
        // 2: max values, no overflow
        for (int i = 0; i < 8; i++) beat(16'hFFFF);
        check("t2_valid", 32'(bus.out_valid), 1);
        check("t2_sum", 32'(bus.out_sum), 32'h7FFF8);
        check("t2_frame", 32'(bus.out_frame), 1);
        idle();
        // 3: back-pressure holds result and stalls input without losing beats
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) beat(16'd3);
        bus.in_data = 16'd5;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_in_ready_low", 32'(bus.in_ready), 0);
            check("t3_hold_valid", 32'(bus.out_valid), 1);
            check("t3_hold_sum", 32'(bus.out_sum), 24);
            check("t3_hold_frame", 32'(bus.out_frame), 2);
        end
        bus.out_ready = 1'b1;
        #1;
        check("t3_in_ready_release", 32'(bus.in_ready), 1);
        step();
        check("t3_drained", 32'(bus.out_valid), 0);
        for (int i = 0; i < 7; i++) beat(16'd5);
        check("t3_next_valid", 32'(bus.out_valid), 1);
        check("t3_next_sum", 32'(bus.out_sum), 40);
        check("t3_next_frame", 32'(bus.out_frame), 3);
        idle();
        // 4: streaming with no bubbles, frame counter wraps
        exp_f = 4;
        prev_f = -1;
        wrap_seen = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd1;
        for (int k = 1; k <= 2048; k++) begin
            check("t4_in_ready", 32'(bus.in_ready), 1);
            step();
            check("t4_valid", 32'(bus.out_valid), 32'(k % 8 == 0));
            if (k % 8 == 0) begin
                check("t4_sum", 32'(bus.out_sum), 8);
                check("t4_frame", 32'(bus.out_frame), 32'(exp_f));
                if (prev_f == 255 && bus.out_frame == 8'd0) wrap_seen = 1'b1;
                prev_f = int'(bus.out_frame);
                exp_f = (exp_f + 1) % 256;
            end
        end
        check("t4_wrap_seen", 32'(wrap_seen), 1);
        idle();
        check("t4_end_valid", 32'(bus.out_valid), 0);
        // 5: async reset mid-frame
        for (int i = 0; i < 3; i++) beat(16'd50);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(bus.out_valid), 0);
        check("t5_rst_sum", 32'(bus.out_sum), 0);
        check("t5_rst_frame", 32'(bus.out_frame), 0);
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) beat(16'd10);
        check("t5_valid", 32'(bus.out_valid), 1);
        check("t5_sum", 32'(bus.out_sum), 80);
        check("t5_frame", 32'(bus.out_frame), 0);
        idle();
        // 6: flush while holding a result, then flush with a beat in ACC
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) beat(16'd4);
        check("t6_held_sum", 32'(bus.out_sum), 32);
        check("t6_held_frame", 32'(bus.out_frame), 1);
        clr_i = 1'b1;
        bus.in_data = 16'd99;
        #1;
        check("t6_in_ready_out", 32'(bus.in_ready), 0);
        step();
        check("t6_clr_valid", 32'(bus.out_valid), 0);
        check("t6_clr_sum_kept", 32'(bus.out_sum), 32);
        check("t6_clr_frame_kept", 32'(bus.out_frame), 1);
        check("t6_in_ready_acc", 32'(bus.in_ready), 1);
        step();
        clr_i = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) beat(16'd2);
        check("t6_no_early", 32'(bus.out_valid), 0);
        beat(16'd2);
        check("t6_valid", 32'(bus.out_valid), 1);
        check("t6_sum", 32'(bus.out_sum), 16);
        check("t6_frame", 32'(bus.out_frame), 2);
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
